// File: rtl/latency_memory.sv
// Fixed-latency word memory with byte addressing relative to a base offset.
// Optional macro BYTE_WSTRB_EN adds per-byte write strobes (req_wstrb).
module latency_memory #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WORD_DEPTH = 100,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   offset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef BYTE_WSTRB_EN
    input  logic [DATA_W/8-1:0] req_wstrb,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);
    localparam int unsigned IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [DATA_W-1:0] mem [0:WORD_DEPTH-1];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  offset_q, offset_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
`ifdef BYTE_WSTRB_EN
    logic [BYTES-1:0]   wstrb_q, wstrb_d;
`endif
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0]  diff_c;
    logic [ADDR_W-1:0]  index_c;
    logic [IDX_W-1:0]   idx_c;
    logic               err_c;
    logic               commit_c;
    logic [DATA_W-1:0]  wr_word_c;

    // Address decode on the latched request
    always_comb begin
        diff_c   = addr_q - offset_q;
        index_c  = diff_c >> SHIFT;
        idx_c    = IDX_W'(index_c);
        err_c    = (addr_q < offset_q) ||
                   (index_c >= ADDR_W'(WORD_DEPTH)) ||
                   ((addr_q & ADDR_W'(BYTES - 1)) != '0);
        commit_c = (state_q == RESP) && wen_q && !err_c;
    end

    // Merged write word: strobed bytes from the request, the rest from storage
    always_comb begin
`ifdef BYTE_WSTRB_EN
        wr_word_c = mem[idx_c];
        for (int b = 0; b < int'(BYTES); b++) begin
            if (wstrb_q[b]) begin
                wr_word_c[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
`else
        wr_word_c = wdata_q;
`endif
    end

    // Next state; the response is registered on the edge that leaves RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
`ifdef BYTE_WSTRB_EN
        wstrb_d     = wstrb_q;
`endif
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    addr_d   = req_addr;
                    offset_d = offset;
                    wdata_d  = req_wdata;
`ifdef BYTE_WSTRB_EN
                    wstrb_d  = req_wstrb;
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_c;
                if (!wen_q && !err_c) begin
                    rsp_rdata_d = mem[idx_c];
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            offset_q    <= '0;
            wdata_q     <= '0;
`ifdef BYTE_WSTRB_EN
            wstrb_q     <= '0;
`endif
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
`ifdef BYTE_WSTRB_EN
            wstrb_q     <= wstrb_d;
`endif
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; a reset forces IDLE, so no commit can follow it
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[idx_c] <= wr_word_c;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_latency_memory.sv
// Randomized self-checking bench for latency_memory (LATENCY=4 and LATENCY=1 instances).
module tb_latency_memory;

    localparam int L = 4;
    localparam logic [31:0] OFFSET = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] offset;
    logic        req_valid, req_wen;
    logic        req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_req_addr, b_rsp_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [0:99];

    always #5 clk = ~clk;

    latency_memory #(.DATA_W(32), .WORD_DEPTH(100), .ADDR_W(32), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .offset(offset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef BYTE_WSTRB_EN
        .req_wstrb(req_wstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    latency_memory #(.DATA_W(32), .WORD_DEPTH(100), .ADDR_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .offset(offset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(1'b0),
        .req_addr(b_req_addr), .req_wdata(32'h0),
`ifdef BYTE_WSTRB_EN
        .req_wstrb(4'h0),
`endif
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    function automatic logic model_err(input logic [31:0] addr);
        logic [31:0] diff;
        if (addr < OFFSET) return 1'b1;
        if (addr[1:0] != 2'b00) return 1'b1;
        diff = addr - OFFSET;
        return (diff / 4) >= 100;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        dut.mem[idx] = val;
        model_mem[idx] = val;
    endtask

    // One request through the L=4 instance, checked against the model
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input string name);
        logic [31:0] exp_rd, got_rd, m32;
        logic [3:0]  eff;
        logic        exp_err, got_err, ready_bad;
        int          rsp_k, npulse, waitc, idx;
        exp_err = model_err(addr);
        idx = int'((addr - OFFSET) / 4);
        exp_rd = (!wen && !exp_err) ? model_mem[idx] : 32'h0;
        eff = strb;
`ifndef BYTE_WSTRB_EN
        eff = 4'hF;
`endif
        if (wen && !exp_err) begin
            m32 = {{8{eff[3]}}, {8{eff[2]}}, {8{eff[1]}}, {8{eff[0]}}};
            model_mem[idx] = (model_mem[idx] & ~m32) | (wdata & m32);
        end
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_timeout: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_k = -1; npulse = 0; ready_bad = 1'b0; got_rd = 32'h0; got_err = 1'b0;
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                npulse++;
                if (rsp_k < 0) begin
                    rsp_k = k; got_rd = rsp_rdata; got_err = rsp_err;
                end
            end
            if (k < L && req_ready !== 1'b0) ready_bad = 1'b1;
            if (k == L && req_ready !== 1'b1) ready_bad = 1'b1;
        end
        tests_run += 5;
        if (rsp_k !== L) begin
            tests_failed++; $display("FAIL %s latency: got %0d want %0d", name, rsp_k, L);
        end
        if (npulse !== 1) begin
            tests_failed++; $display("FAIL %s pulses: got %0d want 1", name, npulse);
        end
        if (ready_bad) begin
            tests_failed++; $display("FAIL %s ready_pattern: got bad want low until response", name);
        end
        if (got_rd !== exp_rd) begin
            tests_failed++; $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
        end
        if (got_err !== exp_err) begin
            tests_failed++; $display("FAIL %s err: got %b want %b", name, got_err, exp_err);
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) if (dut.mem[i] !== model_mem[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL %s mem: got %0d differing words want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 4;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset err: got %b want 0", rsp_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preload_read();
        preload(2, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0001_0008, 32'h0, 4'h0, "preload_read");
    endtask

    task automatic test_write_read();
        do_req(1'b1, 32'h0001_0010, 32'h1234_5678, 4'hF, "write");
        tests_run++;
        if (dut.mem[4] !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL write_commit: got %h want 12345678", dut.mem[4]);
        end
        do_req(1'b0, 32'h0001_0010, 32'h0, 4'h0, "read_after_write");
    endtask

    // Hold valid high; response and ready must recur with period lat+1
    task automatic test_back_to_back(input int sel);
        int lat, bad, pulses;
        logic [31:0] exp_rd;
        lat = (sel == 0) ? L : 1;
        exp_rd = (sel == 0) ? 32'h1234_5678 : 32'h5A5A_0F0F;
        bad = 0; pulses = 0;
        if (sel == 0) begin
            req_wen = 1'b0; req_addr = 32'h0001_0010; req_valid = 1'b1;
        end else begin
            dut1.mem[7] = 32'h5A5A_0F0F;
            b_req_addr = 32'h0001_001C; b_req_valid = 1'b1;
        end
        @(negedge clk);
        for (int k = 1; k <= 3 * (lat + 1) - 1; k++) begin
            logic rv, rr, exp_hi;
            logic [31:0] rd;
            @(negedge clk);
            rv = (sel == 0) ? rsp_valid : b_rsp_valid;
            rr = (sel == 0) ? req_ready : b_req_ready;
            rd = (sel == 0) ? rsp_rdata : b_rsp_rdata;
            exp_hi = ((k % (lat + 1)) == lat);
            if (rv !== exp_hi || rr !== exp_hi) bad++;
            if (rv === 1'b1) begin
                pulses++;
                if (rd !== exp_rd) bad++;
            end
        end
        req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (lat + 2) @(negedge clk);
        tests_run += 2;
        if (bad != 0) begin
            tests_failed++; $display("FAIL back_to_back_lat%0d pattern: got %0d bad cycles want 0", lat, bad);
        end
        if (pulses != 3) begin
            tests_failed++; $display("FAIL back_to_back_lat%0d pulses: got %0d want 3", lat, pulses);
        end
    endtask

    task automatic test_errors();
        do_req(1'b0, 32'h0000_FFFC, 32'h0, 4'h0, "err_below");
        do_req(1'b0, 32'h0001_0190, 32'h0, 4'h0, "err_index100");
        do_req(1'b0, 32'h0001_0001, 32'h0, 4'h0, "err_unaligned");
        do_req(1'b1, 32'h0001_0190, 32'hFFFF_FFFF, 4'hF, "err_write");
        check_mem("err_write");
    endtask

    task automatic test_strobe();
        logic [31:0] exp;
        preload(1, 32'hAABB_CCDD);
        do_req(1'b1, 32'h0001_0004, 32'h1122_3344, 4'b0101, "strobe_write");
`ifdef BYTE_WSTRB_EN
        exp = 32'hAA22_CC44;
`else
        exp = 32'h1122_3344;
`endif
        tests_run++;
        if (dut.mem[1] !== exp) begin
            tests_failed++; $display("FAIL strobe mem1: got %h want %h", dut.mem[1], exp);
        end
        do_req(1'b1, 32'h0001_0004, 32'h9999_9999, 4'b0000, "strobe_zero");
        check_mem("strobe_zero");
    endtask

    task automatic test_reset_mid();
        int seen;
        preload(8, 32'hCAFE_F00D);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0001_0020; req_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        tests_run += 3;
        if (seen != 0) begin tests_failed++; $display("FAIL reset_mid rsp_valid: got %0d pulses want 0", seen); end
        if (dut.mem[8] !== 32'hCAFE_F00D) begin
            tests_failed++; $display("FAIL reset_mid mem8: got %h want cafef00d", dut.mem[8]);
        end
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mid ready: got %b want 1", req_ready); end
        do_req(1'b0, 32'h0001_0020, 32'h0, 4'h0, "reset_mid_read");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = OFFSET + 32'($urandom_range(0, 99)) * 4;
            else if (r == 7) addr = OFFSET + 32'($urandom_range(100, 120)) * 4;
            else if (r == 8) addr = OFFSET - 32'($urandom_range(1, 4)) * 4;
            else             addr = OFFSET + 32'($urandom_range(0, 99)) * 4 + 32'($urandom_range(1, 3));
            do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), "random");
        end
        check_mem("random");
    endtask

    initial begin
        rst = 1'b1; offset = OFFSET;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        b_req_valid = 1'b0; b_req_addr = 32'h0;
        for (int i = 0; i < 100; i++) preload(i, 32'($urandom));
        @(negedge clk);
        test_reset();
        test_preload_read();
        test_write_read();
        test_back_to_back(0);
        test_back_to_back(1);
        test_errors();
        test_strobe();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
